shift_register_param: RTL and testbench

- Parametrised universal shift register; next generation of the team's 4-bit load/shift/rotate register.
- Adds:
  - generic WIDTH
  - multi-bit shift amounts, executed one bit per clock under a start/busy/done handshake
  - arithmetic right shift
  - serial in/out for chaining
- Sits in datapath blocks needing sequenced shifts (serialisers, normalisers, bit-stream generators).

---
 rtl/shift_register_param.sv | 134 +++++++++++++
 tb/tb_shift_register_param.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_register_param.sv
// Parametrised universal shift register.
// Supports parallel load, multi-bit shift/rotate/arithmetic-shift sequences
// executed one bit per clock, and a serial in/out path for chaining.
module shift_register_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  localparam logic [2:0] MODE_SHL = 3'b000;
  localparam logic [2:0] MODE_SHR = 3'b001;
  localparam logic [2:0] MODE_ROL = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ASR = 3'b100;

  state_e           state, state_n;
  logic [AMT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_q, mode_n;
  logic [WIDTH-1:0] op_n;
  logic             ser_n;
  logic             busy_n;
  logic             done_n;

  // State, latched operation and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mode_q  <= '0;
      op      <= '0;
      ser_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state   <= state_n;
      cnt     <= cnt_n;
      mode_q  <= mode_n;
      op      <= op_n;
      ser_out <= ser_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Next-state, single-step datapath and handshake outputs.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    op_n    = op;
    ser_n   = ser_out;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (load) begin
          // Load wins over a simultaneous start; that start is dropped.
          op_n = ld_data;
        end else if (start) begin
          if (amt == '0) begin
            done_n = 1'b1;
          end else begin
            mode_n  = mode;
            cnt_n   = amt;
            state_n = SHIFT;
            busy_n  = 1'b1;
          end
        end
      end

      SHIFT: begin
        unique case (mode_q)
          MODE_SHL: begin
            op_n  = {op[WIDTH-2:0], ser_in};
            ser_n = op[WIDTH-1];
          end
          MODE_SHR: begin
            op_n  = {ser_in, op[WIDTH-1:1]};
            ser_n = op[0];
          end
          MODE_ROL: begin
            op_n  = {op[WIDTH-2:0], op[WIDTH-1]};
            ser_n = op[WIDTH-1];
          end
          MODE_ROR: begin
            op_n  = {op[0], op[WIDTH-1:1]};
            ser_n = op[0];
          end
          MODE_ASR: begin
            op_n  = {op[WIDTH-1], op[WIDTH-1:1]};
            ser_n = op[0];
          end
          default: begin
            // Reserved modes step the counter but leave the data alone.
            op_n  = op;
            ser_n = ser_out;
          end
        endcase

        cnt_n = cnt - AMT_W'(1);
        if (cnt == AMT_W'(1)) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          busy_n = 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_register_param.sv
// Testbench for shift_register_param: directed vectors, scoreboard of
// expected completion results checked by an independent done monitor.
module tb_shift_register_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] ld_data;
  logic       start;
  logic [2:0] mode;
  logic [2:0] amt;
  logic       ser_in;
  logic [7:0] op;
  logic       ser_out;
  logic       busy;
  logic       done;

  // Narrow instance for the amt >= WIDTH wrap case.
  logic       b_load;
  logic [3:0] b_ld_data;
  logic       b_start;
  logic [2:0] b_mode;
  logic [2:0] b_amt;
  logic       b_ser_in;
  logic [3:0] b_op;
  logic       b_ser_out;
  logic       b_busy;
  logic       b_done;

  typedef struct {
    logic [7:0] op;
    logic       ser;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_run = 0;

  shift_register_param #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .load(load), .ld_data(ld_data), .start(start),
    .mode(mode), .amt(amt), .ser_in(ser_in), .op(op), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  shift_register_param #(.WIDTH(4), .AMT_W(3)) dut4 (
    .clk(clk), .rst(rst), .load(b_load), .ld_data(b_ld_data), .start(b_start),
    .mode(b_mode), .amt(b_amt), .ser_in(b_ser_in), .op(b_op), .ser_out(b_ser_out),
    .busy(b_busy), .done(b_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load    = 1'b1;
    ld_data = v;
    tick();
    load    = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] m, input logic [2:0] a, input bit push,
                          input logic [7:0] e_op, input logic e_ser, input int e_busy);
    exp_t e;
    if (push) begin
      e.op          = e_op;
      e.ser         = e_ser;
      e.busy_cycles = e_busy;
      sb.push_back(e);
    end
    mode  = m;
    amt   = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Monitor: counts busy cycles and checks each done pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("done_op", 32'(op), 32'(e.op));
          check("done_ser_out", 32'(ser_out), 32'(e.ser));
          check("done_busy_cycles", 32'(busy_run), 32'(e.busy_cycles));
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; ld_data = '0; start = 1'b0; mode = '0; amt = '0; ser_in = 1'b0;
    b_load = 1'b0; b_ld_data = '0; b_start = 1'b0; b_mode = '0; b_amt = '0; b_ser_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_op", 32'(op), 32'h00);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);

    // Asynchronous reset takes effect between edges.
    do_load(8'h5A);
    check("load_op", 32'(op), 32'h5A);
    #2 rst = 1'b1;
    #1;
    check("async_rst_op", 32'(op), 32'h00);
    check("async_rst_ser_out", 32'(ser_out), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Rotate left by 3 on 0xB4.
    do_load(8'hB4);
    do_start(3'b010, 3'd3, 1'b1, 8'hA5, 1'b1, 3);
    check("rol_busy_start", 32'(busy), 32'h1);
    check("rol_op0", 32'(op), 32'hB4);
    tick(); check("rol_op1", 32'(op), 32'h69);
    tick(); check("rol_op2", 32'(op), 32'hD2);
    tick(); check("rol_op3", 32'(op), 32'hA5);
    check("rol_done", 32'(done), 32'h1);
    check("rol_busy_end", 32'(busy), 32'h0);
    tick(); check("rol_done_clear", 32'(done), 32'h0);

    // Arithmetic shift right by 2 on 0x90; load keeps ser_out.
    do_load(8'h90);
    check("load_keeps_ser_out", 32'(ser_out), 32'h1);
    do_start(3'b100, 3'd2, 1'b1, 8'hE4, 1'b0, 2);
    tick(); check("asr_op1", 32'(op), 32'hC8);
    tick(); check("asr_op2", 32'(op), 32'hE4);
    check("asr_ser_out", 32'(ser_out), 32'h0);
    tick();

    // Shift left by 4 with ser_in=1 on 0x0F.
    ser_in = 1'b1;
    do_load(8'h0F);
    do_start(3'b000, 3'd4, 1'b1, 8'hFF, 1'b0, 4);
    tick(); check("shl_op1", 32'(op), 32'h1F);
    tick(); check("shl_op2", 32'(op), 32'h3F);
    tick(); check("shl_op3", 32'(op), 32'h7F);
    tick(); check("shl_op4", 32'(op), 32'hFF);
    tick();
    ser_in = 1'b0;

    // amt=0: done next cycle, no busy; then a start issued in the done cycle.
    do_start(3'b001, 3'd0, 1'b1, 8'hFF, 1'b0, 0);
    check("amt0_done", 32'(done), 32'h1);
    check("amt0_busy", 32'(busy), 32'h0);
    check("amt0_op", 32'(op), 32'hFF);
    do_start(3'b001, 3'd1, 1'b1, 8'h7F, 1'b1, 1);
    check("start_in_done_busy", 32'(busy), 32'h1);
    check("start_in_done_done", 32'(done), 32'h0);
    tick(); check("shr1_op", 32'(op), 32'h7F);
    tick();

    // Load and start together: load wins, no operation.
    load = 1'b1; ld_data = 8'h3C; start = 1'b1; mode = 3'b010; amt = 3'd2;
    tick();
    load = 1'b0; start = 1'b0;
    check("ldst_op", 32'(op), 32'h3C);
    check("ldst_busy", 32'(busy), 32'h0);
    tick();
    check("ldst_done", 32'(done), 32'h0);
    check("ldst_op_hold", 32'(op), 32'h3C);

    // Load while busy is ignored.
    do_start(3'b000, 3'd2, 1'b1, 8'hF0, 1'b0, 2);
    load = 1'b1; ld_data = 8'hFF;
    tick();
    load = 1'b0;
    check("busy_load_ignored", 32'(op), 32'h78);
    tick(); check("busy_load_final", 32'(op), 32'hF0);
    tick();

    // Reserved mode: counts 5 steps, data untouched.
    do_start(3'b110, 3'd5, 1'b1, 8'hF0, 1'b0, 5);
    repeat (4) tick();
    check("rsvd_busy", 32'(busy), 32'h1);
    tick();
    check("rsvd_done", 32'(done), 32'h1);
    check("rsvd_op", 32'(op), 32'hF0);
    tick();

    // Reset in the middle of a rotate right by 7.
    do_load(8'h01);
    do_start(3'b011, 3'd7, 1'b0, 8'h00, 1'b0, 0);
    tick(); check("ror_op1", 32'(op), 32'h80);
    check("ror_ser1", 32'(ser_out), 32'h1);
    tick(); check("ror_op2", 32'(op), 32'h40);
    #2 rst = 1'b1;
    #1;
    check("midop_rst_op", 32'(op), 32'h00);
    check("midop_rst_busy", 32'(busy), 32'h0);
    check("midop_rst_done", 32'(done), 32'h0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("post_rst_idle_busy", 32'(busy), 32'h0);
    check("post_rst_idle_op", 32'(op), 32'h00);

    // WIDTH=4: ROL by 7 on 0x3 wraps to 0x9.
    b_load = 1'b1; b_ld_data = 4'h3;
    tick();
    b_load = 1'b0;
    b_mode = 3'b010; b_amt = 3'd7; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 20 && !b_done; i++) tick();
    check("w4_done_seen", 32'(b_done), 32'h1);
    check("w4_rol7_op", 32'(b_op), 32'h9);
    check("w4_rol7_ser_out", 32'(b_ser_out), 32'h1);
    tick();

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
